test_seq: RTL

- Run-level controller for the arithmetic testbench.
- Sequences one test run end to end:
  - resets the checking monitor;
  - generates pseudo-random operand pairs for the DUT and the monitor;
  - observes the monitor's mismatch event line.
- Reports status, error count and first-failure position.
- Sits between the host/top-level control and the DUT + monitor pair, all on clk.

---
 rtl/test_seq.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/test_seq.sv
// Run-level controller for the arithmetic testbench: resets the monitor, streams
// Galois-LFSR operand pairs to DUT and monitor, and tallies monitor mismatch events.
module test_seq #(
    parameter int unsigned WIDTH         = 32,
    parameter int unsigned WARMUP_CYCLES = 8,
    parameter int unsigned DRAIN_CYCLES  = 8,
    parameter int unsigned ERR_W         = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic [31:0]      i_num_vec,
    input  logic [31:0]      i_seed,
    input  logic             i_stop_on_fail,
    input  logic             i_abort,
    input  logic             i_event,
    output logic             o_mon_reset,
    output logic [WIDTH-1:0] o_dut_ia,
    output logic [WIDTH-1:0] o_dut_ib,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_fail,
    output logic             o_aborted,
    output logic [ERR_W-1:0] o_err_count,
    output logic [31:0]      o_vec_count,
    output logic [31:0]      o_first_err_idx
);

    typedef enum logic [2:0] {S_IDLE, S_MRST, S_WARMUP, S_RUN, S_DRAIN} state_t;

    localparam logic [WIDTH-1:0] TAPS       = WIDTH'(32'h80200003);
    localparam logic [31:0]      WARM_LAST  = 32'(WARMUP_CYCLES - 1);
    localparam logic [31:0]      DRAIN_LAST = 32'(DRAIN_CYCLES - 1);

    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
        return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
    endfunction

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [31:0]        num_vec_q, num_vec_d;
    logic               stop_q, stop_d;
    logic [31:0]        cnt_q, cnt_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic [31:0]        vec_q, vec_d;
    logic [31:0]        first_q, first_d;
    logic               done_q, done_d;
    logic               fail_q, fail_d;
    logic               aborted_q, aborted_d;
    logic               mon_rst_q, mon_rst_d;
    logic               step;

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        num_vec_d = num_vec_q;
        stop_d    = stop_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        vec_d     = vec_q;
        first_d   = first_q;
        done_d    = done_q;
        fail_d    = fail_q;
        aborted_d = aborted_q;
        step      = 1'b0;

        if (i_abort && state_q != S_IDLE) begin
            state_d   = S_IDLE;
            done_d    = 1'b1;
            aborted_d = 1'b1;
        end else begin
            // Events only count in RUN/DRAIN; the first one latches the vector index.
            if ((state_q == S_RUN || state_q == S_DRAIN) && i_event) begin
                err_d  = (err_q == '1) ? err_q : err_q + ERR_W'(1);
                fail_d = 1'b1;
                if (!fail_q) first_d = vec_q;
            end
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        state_d   = S_MRST;
                        num_vec_d = i_num_vec;
                        stop_d    = i_stop_on_fail;
                        a_d       = (i_seed == '0) ? WIDTH'(1) : i_seed;
                        b_d       = (~i_seed == '1) ? WIDTH'(1) : ~i_seed;
                        err_d     = '0;
                        vec_d     = '0;
                        first_d   = '0;
                        done_d    = 1'b0;
                        fail_d    = 1'b0;
                        aborted_d = 1'b0;
                    end
                end
                S_MRST: begin
                    state_d = S_WARMUP;
                    cnt_d   = '0;
                end
                S_WARMUP: begin
                    if (cnt_q == WARM_LAST) begin
                        cnt_d = '0;
                        if (num_vec_q == '0) begin
                            state_d = S_DRAIN;
                        end else begin
                            state_d = S_RUN;
                            step    = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                        step  = 1'b1;
                    end
                end
                S_RUN: begin
                    vec_d = vec_q + 32'd1;
                    cnt_d = '0;
                    // The last RUN vector is not stepped past so DRAIN holds it.
                    if (vec_q == num_vec_q - 32'd1 || (stop_q && i_event && !fail_q))
                        state_d = S_DRAIN;
                    else
                        step = 1'b1;
                end
                S_DRAIN: begin
                    if (cnt_q == DRAIN_LAST) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
            if (step) begin
                a_d = lfsr_step(a_q);
                b_d = lfsr_step(b_q);
            end
        end
        mon_rst_d = (state_d == S_MRST);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            num_vec_q <= '0;
            stop_q    <= 1'b0;
            cnt_q     <= '0;
            err_q     <= '0;
            vec_q     <= '0;
            first_q   <= '0;
            done_q    <= 1'b0;
            fail_q    <= 1'b0;
            aborted_q <= 1'b0;
            mon_rst_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            num_vec_q <= num_vec_d;
            stop_q    <= stop_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            vec_q     <= vec_d;
            first_q   <= first_d;
            done_q    <= done_d;
            fail_q    <= fail_d;
            aborted_q <= aborted_d;
            mon_rst_q <= mon_rst_d;
        end
    end

    assign o_mon_reset     = mon_rst_q;
    assign o_dut_ia        = a_q;
    assign o_dut_ib        = b_q;
    assign o_busy          = (state_q != S_IDLE);
    assign o_done          = done_q;
    assign o_fail          = fail_q;
    assign o_aborted       = aborted_q;
    assign o_err_count     = err_q;
    assign o_vec_count     = vec_q;
    assign o_first_err_idx = first_q;

endmodule
